// File: rtl/memarb_pkg.sv
// Shared types for the on-chip memory arbiter: arbiter states, the read-response tag
// and the hold-counter sizing.
package memarb_pkg;

    localparam int HOLD_MAX_LIMIT = 15;
    localparam int HOLD_W         = $clog2(HOLD_MAX_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Captured at accept, consumed one cycle later to steer the memory output.
    typedef struct packed {
        logic valid;
        logic master;
        logic oob;
    } resp_tag_t;

endpackage

// File: rtl/rr_hold_arbiter.sv
// Two-way round-robin arbiter with a bounded hold: the owner keeps the memory for up to
// HOLD_MAX consecutive accepts while the other master waits.
module rr_hold_arbiter
    import memarb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       stall,
    input  logic [1:0] req,
    output logic       accept,
    output logic       grant
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

    arb_state_t        state_reg, state_next;
    logic              last_grant_reg, last_grant_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              owner;
    logic              owner_req;
    logic              other_req;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            hold_cnt_reg   <= '0;
        end else if (!stall) begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            hold_cnt_reg   <= hold_cnt_next;
        end
    end

    assign owner     = (state_reg == OWN1);
    assign owner_req = req[owner];
    assign other_req = req[~owner];

    // The next state always names the master accepted this cycle, or IDLE if none.
    always_comb begin
        state_next      = IDLE;
        last_grant_next = last_grant_reg;
        hold_cnt_next   = '0;
        case (state_reg)
            OWN0, OWN1: begin
                if (owner_req && ((hold_cnt_reg < HOLD_LIM) || !other_req)) begin
                    state_next    = state_reg;
                    hold_cnt_next = (hold_cnt_reg < HOLD_LIM) ? hold_cnt_reg + 1'b1 : hold_cnt_reg;
                end else if (other_req) begin
                    state_next      = owner ? OWN0 : OWN1;
                    hold_cnt_next   = HOLD_W'(1);
                    last_grant_next = ~owner;
                end
            end
            default: begin
                if (req[0] && (!req[1] || last_grant_reg)) begin
                    state_next      = OWN0;
                    hold_cnt_next   = HOLD_W'(1);
                    last_grant_next = 1'b0;
                end else if (req[1]) begin
                    state_next      = OWN1;
                    hold_cnt_next   = HOLD_W'(1);
                    last_grant_next = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        accept = !stall && (state_next != IDLE);
        grant  = (state_next == OWN1);
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares one single-port on-chip memory between two Avalon-MM masters: arbitration,
// request muxing, range checking and routing of the one-cycle read response.
module onchip_memory_arbiter
    import memarb_pkg::*;
#(
    parameter int DEPTH    = 10240,
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,
    input  logic [AW-1:0]     m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DW-1:0]     m0_writedata,
    input  logic [DW/8-1:0]   m0_byteenable,
    input  logic              m0_debugaccess,
    output logic              m0_waitrequest,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [AW-1:0]     m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DW-1:0]     m1_writedata,
    input  logic [DW/8-1:0]   m1_byteenable,
    input  logic              m1_debugaccess,
    output logic              m1_waitrequest,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_readdatavalid,
    output logic [AW-1:0]     mem_address,
    output logic [DW/8-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DW-1:0]     mem_writedata,
    output logic              mem_debugaccess,
    output logic              mem_clken,
    input  logic [DW-1:0]     mem_readdata,
    output logic              range_err
);

    logic [1:0]      req;
    logic            accept;
    logic            grant;

    logic [AW-1:0]   addr_arr [2];
    logic [DW/8-1:0] be_arr   [2];
    logic [DW-1:0]   wd_arr   [2];
    logic [1:0]      rd_arr;
    logic [1:0]      wr_arr;
    logic [1:0]      dbg_arr;

    logic [AW-1:0]   sel_address;
    logic            sel_read;
    logic            sel_write;
    logic            out_of_range;

    resp_tag_t       tag_reg, tag_next;
    logic            range_err_reg;
    logic [1:0]      rd_valid;
    logic [DW-1:0]   rd_data [2];

    assign addr_arr[0] = m0_address;
    assign addr_arr[1] = m1_address;
    assign be_arr[0]   = m0_byteenable;
    assign be_arr[1]   = m1_byteenable;
    assign wd_arr[0]   = m0_writedata;
    assign wd_arr[1]   = m1_writedata;
    assign rd_arr      = {m1_read, m0_read};
    assign wr_arr      = {m1_write, m0_write};
    assign dbg_arr     = {m1_debugaccess, m0_debugaccess};
    assign req         = rd_arr | wr_arr;

    rr_hold_arbiter #(
        .HOLD_MAX (HOLD_MAX)
    ) u_arbiter (
        .clk    (clk),
        .srst   (reset),
        .stall  (reset_req),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        sel_address  = addr_arr[grant];
        sel_read     = rd_arr[grant];
        sel_write    = wr_arr[grant];
        out_of_range = (32'(sel_address) >= 32'(DEPTH));
    end

    // Out-of-range accesses never reach the memory; read+write together counts as a read.
    assign mem_address     = sel_address;
    assign mem_byteenable  = be_arr[grant];
    assign mem_writedata   = wd_arr[grant];
    assign mem_debugaccess = dbg_arr[grant];
    assign mem_chipselect  = accept && !out_of_range;
    assign mem_write       = accept && !out_of_range && sel_write && !sel_read;
    assign mem_clken       = !reset_req;

    assign m0_waitrequest = req[0] && !(accept && !grant);
    assign m1_waitrequest = req[1] && !(accept && grant);

    always_comb begin
        tag_next        = '0;
        tag_next.valid  = accept && sel_read;
        tag_next.master = grant;
        tag_next.oob    = out_of_range;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_reg       <= '0;
            range_err_reg <= 1'b0;
        end else begin
            tag_reg <= tag_next;
            if (accept && out_of_range) begin
                range_err_reg <= 1'b1;
            end
        end
    end

    assign range_err = range_err_reg;

    // The memory output belongs to whichever master the tag names; others see zero.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign rd_valid[gi] = tag_reg.valid && (tag_reg.master == 1'(gi));
            assign rd_data[gi]  = (rd_valid[gi] && !tag_reg.oob) ? mem_readdata : '0;
        end
    endgenerate

    assign m0_readdatavalid = rd_valid[0];
    assign m1_readdatavalid = rd_valid[1];
    assign m0_readdata      = rd_data[0];
    assign m1_readdata      = rd_data[1];

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level arbitration model and a shadow copy of the memory image.
module tb_onchip_memory_arbiter;

    localparam int DEPTH    = 10240;
    localparam int AW       = 14;
    localparam int DW       = 32;
    localparam int HOLD_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          reset_req;
    logic [1:0]    rd_i, wr_i, dbg_i;
    logic [AW-1:0] addr_i [2];
    logic [3:0]    be_i   [2];
    logic [31:0]   wd_i   [2];

    logic          m0_waitrequest, m1_waitrequest;
    logic [31:0]   m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect, mem_write, mem_debugaccess, mem_clken;
    logic [31:0]   mem_writedata;
    logic [31:0]   mem_readdata;
    logic          range_err;

    onchip_memory_arbiter #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .m0_address(addr_i[0]), .m0_read(rd_i[0]), .m0_write(wr_i[0]),
        .m0_writedata(wd_i[0]), .m0_byteenable(be_i[0]), .m0_debugaccess(dbg_i[0]),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(addr_i[1]), .m1_read(rd_i[1]), .m1_write(wr_i[1]),
        .m1_writedata(wd_i[1]), .m1_byteenable(be_i[1]), .m1_debugaccess(dbg_i[1]),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_debugaccess(mem_debugaccess),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata), .range_err(range_err)
    );

    // Memory macro: registered read, byte-lane writes only with debugaccess, held when clken=0.
    logic [31:0] mem_array [0:16383];
    logic [31:0] mem_q;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write && mem_debugaccess)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem_array[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            mem_q <= mem_array[mem_address];
        end
    end
    assign mem_readdata = mem_q;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] shadow [0:DEPTH-1];
    int          m_owner;
    int          m_run;
    int          m_last;
    bit          exp_valid;
    int          exp_master;
    logic [31:0] exp_data;
    bit          exp_range_err;

    function automatic logic [31:0] init_word(input int a);
        return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0003);
    endfunction

    function automatic bit req_of(input int m);
        return rd_i[m] | wr_i[m];
    endfunction

    function automatic bit oob_of(input int m);
        return 32'(addr_i[m]) >= DEPTH;
    endfunction

    // Winner of the current cycle, or -1 if nobody is accepted.
    function automatic int predict();
        int o;
        if (reset_req) return -1;
        if (m_owner < 0) begin
            if (req_of(0) && req_of(1)) return 1 - m_last;
            if (req_of(0)) return 0;
            if (req_of(1)) return 1;
            return -1;
        end
        o = m_owner;
        if (req_of(o) && !(m_run >= HOLD_MAX && req_of(1 - o))) return o;
        if (req_of(1 - o)) return 1 - o;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_run = 0; m_last = 1;
        exp_valid = 0; exp_master = 0; exp_data = '0; exp_range_err = 0;
    endtask

    // Commit the cycle's transaction to the model, then move to the next cycle.
    task automatic advance(input int win);
        int a;
        exp_valid = 0;
        if (!reset_req) begin
            if (win < 0) m_owner = -1;
            else begin
                m_run   = (win == m_owner) ? m_run + 1 : 1;
                m_owner = win;
                m_last  = win;
            end
        end
        if (win >= 0) begin
            a = int'(addr_i[win]);
            if (oob_of(win)) exp_range_err = 1;
            if (rd_i[win]) begin
                exp_valid = 1; exp_master = win;
                exp_data = oob_of(win) ? 32'h0 : shadow[a];
            end else if (wr_i[win] && dbg_i[win] && !oob_of(win)) begin
                for (int b = 0; b < 4; b++)
                    if (be_i[win][b]) shadow[a][8*b +: 8] = wd_i[win][8*b +: 8];
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_all();
        rd_i = '0; wr_i = '0; dbg_i = '0;
        for (int m = 0; m < 2; m++) begin addr_i[m] = '0; be_i[m] = 4'hF; wd_i[m] = '0; end
    endtask

    task automatic drive(input int m, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input logic dbg);
        rd_i[m] = rd; wr_i[m] = wr; addr_i[m] = a; be_i[m] = be; wd_i[m] = wd; dbg_i[m] = dbg;
    endtask

    task automatic apply_reset();
        idle_all(); reset_req = 0; reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_all(); reset_req = 0; reset = 1;
        repeat (3) @(posedge clk);
        #4;
        checks++; if ({m0_readdatavalid, m1_readdatavalid, range_err, mem_chipselect} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got rdv0/rdv1/err/cs=%b expected 0000",
                               {m0_readdatavalid, m1_readdatavalid, range_err, mem_chipselect}); end
        checks++; if ({m0_readdata, m1_readdata} !== 64'h0) begin
            errors++; $display("FAIL reset_readdata: got %h/%h expected 0/0", m0_readdata, m1_readdata); end
        checks++; if ({m0_waitrequest, m1_waitrequest, mem_clken} !== 3'b001) begin
            errors++; $display("FAIL reset_wait_clken: got %b expected 001",
                               {m0_waitrequest, m1_waitrequest, mem_clken}); end
        @(posedge clk); #1 reset = 0;
        model_reset();
    endtask

    task automatic test_seq_read();
        int win;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            idle_all();
            if (i < 4) drive(0, 1, 0, AW'(i), 4'hF, 32'h0, 0);
            #4; win = predict();
            if (i < 4) begin
                checks++; if ({m0_waitrequest, mem_chipselect, mem_address} !== {1'b0, 1'b1, AW'(i)}) begin
                    errors++; $display("FAIL seq_accept[%0d]: got wait=%b cs=%b addr=%h expected 0 1 %h",
                                       i, m0_waitrequest, mem_chipselect, mem_address, AW'(i)); end
            end
            checks++; if (m0_readdatavalid !== (i >= 1 && i <= 4)) begin
                errors++; $display("FAIL seq_rdv[%0d]: got %b expected %b", i, m0_readdatavalid, (i >= 1 && i <= 4)); end
            if (i >= 1 && i <= 4) begin
                checks++; if (m0_readdata !== init_word(i - 1)) begin
                    errors++; $display("FAIL seq_data[%0d]: got %h expected %h", i, m0_readdata, init_word(i - 1)); end
            end
            advance(win);
        end
    endtask

    task automatic test_round_robin();
        int win, expw, prevw, prev_addr;
        apply_reset();
        prevw = 0; prev_addr = 0;
        for (int k = 0; k < 17; k++) begin
            idle_all();
            if (k < 16) begin
                drive(0, 1, 0, AW'($urandom_range(0, 31)), 4'hF, 32'h0, 0);
                drive(1, 1, 0, AW'($urandom_range(0, 31)), 4'hF, 32'h0, 0);
            end
            #4; win = predict();
            expw = (k / HOLD_MAX) % 2;
            if (k < 16) begin
                checks++; if ({m0_waitrequest, m1_waitrequest} !== {expw != 0, expw != 1}) begin
                    errors++; $display("FAIL rr_grant[%0d]: got wait0/1=%b%b expected m%0d granted",
                                       k, m0_waitrequest, m1_waitrequest, expw); end
            end
            if (k > 0) begin
                checks++; if ({m0_readdatavalid, m1_readdatavalid} !== {prevw == 0, prevw == 1}) begin
                    errors++; $display("FAIL rr_route[%0d]: got rdv0/1=%b%b expected m%0d", k,
                                       m0_readdatavalid, m1_readdatavalid, prevw); end
                checks++; if ((prevw ? m1_readdata : m0_readdata) !== shadow[prev_addr]) begin
                    errors++; $display("FAIL rr_data[%0d]: got %h expected %h", k,
                                       prevw ? m1_readdata : m0_readdata, shadow[prev_addr]); end
            end
            prevw = expw; prev_addr = int'(addr_i[expw]);
            advance(win);
        end
    endtask

    task automatic test_write_debug();
        logic [31:0] orig, expect_word;
        apply_reset();
        orig = shadow[16];
        expect_word = {orig[31:16], 16'hBEEF};
        for (int c = 0; c < 6; c++) begin
            idle_all();
            case (c)
                0: drive(1, 0, 1, AW'(16), 4'b0011, 32'hDEADBEEF, 1);
                3: drive(1, 0, 1, AW'(16), 4'b1111, 32'h12345678, 0);
                1, 4: drive(1, 1, 0, AW'(16), 4'hF, 32'h0, 0);
                default: ;
            endcase
            #4;
            if (c == 0 || c == 3) begin
                checks++; if ({m1_waitrequest, mem_write, mem_debugaccess, mem_byteenable} !==
                              {1'b0, 1'b1, c == 0, (c == 0) ? 4'b0011 : 4'b1111}) begin
                    errors++; $display("FAIL wr_accept[%0d]: got wait=%b we=%b dbg=%b be=%b", c,
                                       m1_waitrequest, mem_write, mem_debugaccess, mem_byteenable); end
            end
            if (c == 2 || c == 5) begin
                checks++; if ({m1_readdatavalid, m1_readdata} !== {1'b1, expect_word}) begin
                    errors++; $display("FAIL wr_readback[%0d]: got rdv=%b data=%h expected 1 %h", c,
                                       m1_readdatavalid, m1_readdata, expect_word); end
            end
            advance(predict());
        end
    endtask

    task automatic test_out_of_range();
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            idle_all();
            case (c)
                0: drive(0, 1, 0, AW'(DEPTH), 4'hF, 32'h0, 0);
                1: drive(0, 0, 1, AW'(16383), 4'hF, 32'hFFFF_FFFF, 1);
                2: drive(0, 1, 0, AW'(DEPTH - 1), 4'hF, 32'h0, 0);
                default: ;
            endcase
            #4;
            if (c == 0) begin
                checks++; if ({mem_chipselect, m0_waitrequest, range_err} !== 3'b000) begin
                    errors++; $display("FAIL oob_read_cs: got cs/wait/err=%b expected 000",
                                       {mem_chipselect, m0_waitrequest, range_err}); end
            end
            if (c == 1) begin
                checks++; if ({m0_readdatavalid, m0_readdata, range_err} !== {1'b1, 32'h0, 1'b1}) begin
                    errors++; $display("FAIL oob_read_resp: got rdv=%b data=%h err=%b expected 1 0 1",
                                       m0_readdatavalid, m0_readdata, range_err); end
                checks++; if ({mem_chipselect, mem_write} !== 2'b00) begin
                    errors++; $display("FAIL oob_write_drop: got cs/we=%b expected 00", {mem_chipselect, mem_write}); end
            end
            if (c == 2) begin
                checks++; if (mem_chipselect !== 1'b1) begin
                    errors++; $display("FAIL last_word_cs: got %b expected 1", mem_chipselect); end
            end
            if (c == 3) begin
                checks++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, shadow[DEPTH - 1]}) begin
                    errors++; $display("FAIL last_word_data: got rdv=%b data=%h expected 1 %h",
                                       m0_readdatavalid, m0_readdata, shadow[DEPTH - 1]); end
            end
            if (c == 7) begin
                checks++; if (range_err !== 1'b1) begin
                    errors++; $display("FAIL range_err_sticky: got %b expected 1", range_err); end
            end
            advance(predict());
        end
    endtask

    task automatic test_reset_req();
        int win;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            idle_all();
            reset_req = (c == 1 || c == 2);
            if (c == 0) drive(0, 1, 0, AW'(5), 4'hF, 32'h0, 0);
            if (c >= 1 && c <= 3) begin
                drive(0, 1, 0, AW'(6), 4'hF, 32'h0, 0);
                drive(1, 1, 0, AW'(7), 4'hF, 32'h0, 0);
            end
            #4; win = predict();
            if (c == 1) begin
                checks++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, shadow[5]}) begin
                    errors++; $display("FAIL rreq_deliver: got rdv=%b data=%h expected 1 %h",
                                       m0_readdatavalid, m0_readdata, shadow[5]); end
            end
            if (c == 1 || c == 2) begin
                checks++; if ({m0_waitrequest, m1_waitrequest, mem_chipselect, mem_clken} !== 4'b1100) begin
                    errors++; $display("FAIL rreq_stall[%0d]: got wait0/wait1/cs/clken=%b expected 1100", c,
                                       {m0_waitrequest, m1_waitrequest, mem_chipselect, mem_clken}); end
            end
            if (c == 2) begin
                checks++; if (m0_readdatavalid !== 1'b0) begin
                    errors++; $display("FAIL rreq_no_extra_rdv: got %b expected 0", m0_readdatavalid); end
            end
            if (c == 3) begin
                checks++; if ({m0_waitrequest, m1_waitrequest, mem_clken} !== 3'b011) begin
                    errors++; $display("FAIL rreq_resume: got wait0/wait1/clken=%b expected 011",
                                       {m0_waitrequest, m1_waitrequest, mem_clken}); end
            end
            if (c == 4) begin
                checks++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, shadow[6]}) begin
                    errors++; $display("FAIL rreq_resume_data: got rdv=%b data=%h expected 1 %h",
                                       m0_readdatavalid, m0_readdata, shadow[6]); end
            end
            advance(win);
        end
        reset_req = 0;
    endtask

    task automatic test_reset_pending();
        apply_reset();
        drive(1, 1, 0, AW'(12000), 4'hF, 32'h0, 0);
        @(posedge clk); #1;
        idle_all();
        drive(0, 1, 0, AW'(2), 4'hF, 32'h0, 0);
        reset = 1;
        #4;
        checks++; if ({m1_readdatavalid, m1_readdata, range_err} !== {1'b1, 32'h0, 1'b1}) begin
            errors++; $display("FAIL rstp_setup: got rdv1=%b data=%h err=%b expected 1 0 1",
                               m1_readdatavalid, m1_readdata, range_err); end
        @(posedge clk); #1;
        reset = 0; idle_all();
        #4;
        checks++; if ({m0_readdatavalid, m1_readdatavalid, range_err} !== 3'b000) begin
            errors++; $display("FAIL rstp_discard: got rdv0/rdv1/err=%b expected 000",
                               {m0_readdatavalid, m1_readdatavalid, range_err}); end
        checks++; if ({m0_readdata, m1_readdata} !== 64'h0) begin
            errors++; $display("FAIL rstp_readdata: got %h/%h expected 0/0", m0_readdata, m1_readdata); end
        @(posedge clk); #1;
        drive(0, 1, 0, AW'(3), 4'hF, 32'h0, 0);
        drive(1, 1, 0, AW'(4), 4'hF, 32'h0, 0);
        #4;
        checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin
            errors++; $display("FAIL rstp_first_grant: got wait0/wait1=%b expected 01",
                               {m0_waitrequest, m1_waitrequest}); end
        @(posedge clk); #1;
        idle_all();
    endtask

    task automatic test_random_traffic();
        int win, p;
        bit exp_cs, exp_we, w0, w1;
        logic [31:0] got;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            reset_req = ($urandom_range(0, 99) < 8);
            for (int m = 0; m < 2; m++) begin
                p = $urandom_range(0, 99);
                rd_i[m] = (p < 40) || (p >= 60 && p < 63);
                wr_i[m] = (p >= 40 && p < 63);
                p = $urandom_range(0, 99);
                if (p < 85) addr_i[m] = AW'($urandom_range(0, 31));
                else if (p < 95) addr_i[m] = AW'($urandom_range(DEPTH - 4, DEPTH + 3));
                else addr_i[m] = AW'($urandom_range(0, 16383));
                be_i[m]  = 4'($urandom_range(1, 15));
                wd_i[m]  = $urandom;
                dbg_i[m] = ($urandom_range(0, 3) != 0);
            end
            #4; win = predict();
            exp_cs = 0; exp_we = 0;
            if (win >= 0) begin
                exp_cs = !oob_of(win);
                exp_we = exp_cs && wr_i[win] && !rd_i[win];
            end
            w0 = req_of(0) && (win != 0);
            w1 = req_of(1) && (win != 1);
            checks++; if ({m0_waitrequest, m1_waitrequest} !== {w0, w1}) begin
                errors++; $display("FAIL rand_wait[%0d]: got %b%b expected %b%b", i,
                                   m0_waitrequest, m1_waitrequest, w0, w1); end
            checks++; if ({mem_chipselect, mem_write, mem_clken} !== {exp_cs, exp_we, !reset_req}) begin
                errors++; $display("FAIL rand_mem[%0d]: got cs/we/clken=%b%b%b expected %b%b%b", i,
                                   mem_chipselect, mem_write, mem_clken, exp_cs, exp_we, !reset_req); end
            checks++; if ({m0_readdatavalid, m1_readdatavalid} !==
                          {exp_valid && exp_master == 0, exp_valid && exp_master == 1}) begin
                errors++; $display("FAIL rand_rdv[%0d]: got %b%b expected valid=%0d master=%0d", i,
                                   m0_readdatavalid, m1_readdatavalid, exp_valid, exp_master); end
            if (exp_valid) begin
                got = (exp_master == 1) ? m1_readdata : m0_readdata;
                checks++; if (got !== exp_data) begin
                    errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, got, exp_data); end
            end
            checks++; if (range_err !== exp_range_err) begin
                errors++; $display("FAIL rand_range_err[%0d]: got %b expected %b", i, range_err, exp_range_err); end
            advance(win);
        end
        reset_req = 0;
        idle_all();
    endtask

    initial begin
        for (int a = 0; a < 16384; a++) mem_array[a] = init_word(a);
        for (int a = 0; a < DEPTH; a++) shadow[a] = init_word(a);
        mem_q = '0;
        model_reset();

        test_reset();
        test_seq_read();
        test_round_robin();
        test_write_debug();
        test_out_of_range();
        test_reset_req();
        test_reset_pending();
        test_random_traffic();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
